// File: rtl/pwm_pkg.sv
// Shared types and constants for the multi-channel PWM generator.
// The prescaler limit helper turns a 3-bit divide exponent into a terminal count.
package pwm_pkg;

   typedef enum logic {
      PWM_EDGE   = 1'b0,
      PWM_CENTER = 1'b1
   } pwm_mode_e;

   localparam int CONF_W  = 3;
   localparam int PRESC_W = 7;

   // Terminal prescaler count for a divide-by-2^conf tick (0 -> tick every clock).
   function automatic logic [PRESC_W-1:0] presc_limit(input logic [CONF_W-1:0] conf);
      logic [PRESC_W:0] one;
      one = {{PRESC_W{1'b0}}, 1'b1};
      return PRESC_W'((one << conf) - one);
   endfunction

endpackage

// File: rtl/pwm_duty_ctrl.sv
// One PWM channel: button edge detection, saturating duty shadow, period-boundary
// duty load and the registered compare output.
module pwm_duty_ctrl
   import pwm_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int STEP     = 1,
   parameter int DUTY_RST = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             xu,
   input  logic             xd,
   input  logic             boundary,
   input  logic [WIDTH-1:0] cnt,
   output logic [WIDTH-1:0] duty,
   output logic             pwm
);

   localparam logic [WIDTH:0]   PMAX_X     = {1'b0, {WIDTH{1'b1}}};
   localparam logic [WIDTH:0]   STEP_X     = (WIDTH+1)'(STEP);
   localparam logic [WIDTH-1:0] DUTY_RST_W = WIDTH'(DUTY_RST);

   logic             xu_q;
   logic             xd_q;
   logic             rise_u;
   logic             rise_d;
   logic [WIDTH-1:0] duty_sh;
   logic [WIDTH-1:0] duty_act;
   logic [WIDTH-1:0] duty_next;
   logic [WIDTH:0]   sum_up;
   logic [WIDTH:0]   diff_dn;

   // Saturation is decided one bit wider than the duty so nothing wraps.
   always_comb begin
      rise_u    = ena & xu & ~xu_q;
      rise_d    = ena & xd & ~xd_q;
      sum_up    = {1'b0, duty_sh} + STEP_X;
      diff_dn   = {1'b0, duty_sh} - STEP_X;
      duty_next = duty_sh;
      if (rise_u && !rise_d) begin
         duty_next = (sum_up > PMAX_X) ? {WIDTH{1'b1}} : sum_up[WIDTH-1:0];
      end else if (rise_d && !rise_u) begin
         duty_next = ({1'b0, duty_sh} < STEP_X) ? '0 : diff_dn[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         xu_q     <= 1'b0;
         xd_q     <= 1'b0;
         duty_sh  <= DUTY_RST_W;
         duty_act <= DUTY_RST_W;
         pwm      <= 1'b0;
      end else begin
         xu_q    <= xu;
         xd_q    <= xd;
         duty_sh <= duty_next;
         if (boundary) begin
            duty_act <= duty_sh;
         end
         pwm <= ena & (cnt < duty_act);
      end
   end

   assign duty = duty_sh;

endmodule

// File: rtl/pwm_multi_channel_gen.sv
// NCH PWM channels sharing one prescaled edge/center-aligned counter; mode and
// prescaler settings are shadowed and only take effect at period boundaries.
module pwm_multi_channel_gen
   import pwm_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int NCH      = 4,
   parameter int STEP     = 1,
   parameter int DUTY_RST = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   input  logic [NCH-1:0]       xu,
   input  logic [NCH-1:0]       xd,
   input  logic [CONF_W-1:0]    conf,
   input  logic                 mode,
   output logic [NCH-1:0]       pwm,
   output logic [NCH*WIDTH-1:0] duty_o,
   output logic                 period_start
);

   localparam logic [WIDTH-1:0] CNT_TOP = {{(WIDTH-1){1'b1}}, 1'b0};
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   logic [WIDTH-1:0]   cnt;
   logic [WIDTH-1:0]   cnt_next;
   logic               dir_down;
   logic               dir_down_next;
   logic [PRESC_W-1:0] presc;
   logic [PRESC_W-1:0] presc_next;
   pwm_mode_e          mode_act;
   logic [CONF_W-1:0]  conf_act;
   logic               tick;
   logic               boundary;

   // Center mode turns around at CNT_TOP and ends its period on the 1 -> 0 step.
   always_comb begin
      tick          = ena && (presc == presc_limit(conf_act));
      boundary      = 1'b0;
      cnt_next      = cnt;
      dir_down_next = dir_down;
      presc_next    = presc;
      if (ena) begin
         presc_next = tick ? '0 : presc + PRESC_W'(1);
      end
      if (tick) begin
         if (mode_act == PWM_EDGE) begin
            if (cnt == CNT_TOP) begin
               boundary = 1'b1;
               cnt_next = '0;
            end else begin
               cnt_next = cnt + WIDTH'(1);
            end
         end else if (!dir_down) begin
            if (cnt == CNT_TOP) begin
               dir_down_next = 1'b1;
               cnt_next      = cnt - WIDTH'(1);
            end else begin
               cnt_next = cnt + WIDTH'(1);
            end
         end else begin
            if (cnt == CNT_ONE) begin
               boundary      = 1'b1;
               dir_down_next = 1'b0;
               cnt_next      = '0;
            end else begin
               cnt_next = cnt - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= '0;
         dir_down     <= 1'b0;
         presc        <= '0;
         mode_act     <= PWM_EDGE;
         conf_act     <= '0;
         period_start <= 1'b0;
      end else begin
         cnt          <= cnt_next;
         dir_down     <= dir_down_next;
         presc        <= presc_next;
         period_start <= boundary;
         if (boundary) begin
            mode_act <= pwm_mode_e'(mode);
            conf_act <= conf;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
         pwm_duty_ctrl #(
            .WIDTH    (WIDTH),
            .STEP     (STEP),
            .DUTY_RST (DUTY_RST)
         ) u_duty_ctrl (
            .clk      (clk),
            .rst      (rst),
            .ena      (ena),
            .xu       (xu[gi]),
            .xd       (xd[gi]),
            .boundary (boundary),
            .cnt      (cnt),
            .duty     (duty_o[gi*WIDTH +: WIDTH]),
            .pwm      (pwm[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_pwm_multi_channel_gen.sv
// Directed and randomized bench for pwm_multi_channel_gen, checked every cycle against
// a phase-index model of the PWM periods plus hand-computed period/duty expectations.
module tb_pwm_multi_channel_gen;

   localparam int WIDTH    = 4;
   localparam int NCH      = 2;
   localparam int STEP     = 1;
   localparam int DUTY_RST = 0;
   localparam int PMAX     = (1 << WIDTH) - 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 ena;
   logic [NCH-1:0]       xu;
   logic [NCH-1:0]       xd;
   logic [2:0]           conf;
   logic                 mode;
   logic [NCH-1:0]       pwm;
   logic [NCH*WIDTH-1:0] duty_o;
   logic                 period_start;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pwm_multi_channel_gen #(
      .WIDTH    (WIDTH),
      .NCH      (NCH),
      .STEP     (STEP),
      .DUTY_RST (DUTY_RST)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ena          (ena),
      .xu           (xu),
      .xd           (xd),
      .conf         (conf),
      .mode         (mode),
      .pwm          (pwm),
      .duty_o       (duty_o),
      .period_start (period_start)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   // Model: position within the period as a plain phase index; the counter value
   // is derived from it, and the period length follows from the mode.
   int             m_phase, m_div, m_conf, m_mode;
   int             m_sh[NCH];
   int             m_act[NCH];
   logic [NCH-1:0] m_xu_prev, m_xd_prev;
   logic [NCH-1:0] m_pwm;
   logic [NCH*WIDTH-1:0] m_duty;
   logic           m_ps;
   bit             model_valid = 1'b0;

   function automatic int plen(input int md);
      return (md != 0) ? 2 * (PMAX - 1) : PMAX;
   endfunction

   function automatic int cnt_of(input int md, input int ph);
      return (md == 0 || ph <= PMAX - 1) ? ph : 2 * (PMAX - 1) - ph;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         model_valid = 1'b1;
         m_phase = 0; m_div = 0; m_conf = 0; m_mode = 0;
         for (int c = 0; c < NCH; c++) begin
            m_sh[c]  = DUTY_RST;
            m_act[c] = DUTY_RST;
         end
         m_xu_prev = '0; m_xd_prev = '0;
         m_pwm = '0; m_ps = 1'b0;
      end else if (model_valid) begin
         for (int c = 0; c < NCH; c++) begin
            m_pwm[c] = ena && (cnt_of(m_mode, m_phase) < m_act[c]);
         end
         m_ps = 1'b0;
         if (ena) begin
            if (m_div == (1 << m_conf) - 1) begin
               m_div = 0;
               if (m_phase == plen(m_mode) - 1) begin
                  m_phase = 0;
                  for (int c = 0; c < NCH; c++) m_act[c] = m_sh[c];
                  m_mode = int'(mode);
                  m_conf = int'(conf);
                  m_ps   = 1'b1;
               end else begin
                  m_phase++;
               end
            end else begin
               m_div++;
            end
            for (int c = 0; c < NCH; c++) begin
               bit up, dn;
               up = xu[c] && !m_xu_prev[c];
               dn = xd[c] && !m_xd_prev[c];
               if (up && !dn)      m_sh[c] = (m_sh[c] + STEP > PMAX) ? PMAX : m_sh[c] + STEP;
               else if (dn && !up) m_sh[c] = (m_sh[c] < STEP) ? 0 : m_sh[c] - STEP;
            end
         end
         m_xu_prev = xu;
         m_xd_prev = xd;
      end
      for (int c = 0; c < NCH; c++) m_duty[c*WIDTH +: WIDTH] = WIDTH'(m_sh[c]);
   end

   always @(negedge clk) begin
      if (model_valid) begin
         chk("model_pwm", 32'(pwm), 32'(m_pwm));
         chk("model_duty_o", 32'(duty_o), 32'(m_duty));
         chk("model_period_start", 32'(period_start), 32'(m_ps));
      end
   end

   task automatic pulse(input int ch, input bit up);
      @(negedge clk);
      if (up) xu[ch] = 1'b1; else xd[ch] = 1'b1;
      @(negedge clk);
      xu[ch] = 1'b0;
      xd[ch] = 1'b0;
   endtask

   task automatic wait_ps(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!period_start && n < 400);
      if (!period_start) chk("period_start_timeout", 32'(n), 32'd0);
   endtask

   task automatic window(input int len, output int hi0, output int hi1, output int nps);
      hi0 = 0; hi1 = 0; nps = 0;
      repeat (len) begin
         @(negedge clk);
         hi0 += int'(pwm[0]);
         hi1 += int'(pwm[1]);
         nps += int'(period_start);
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog t=%0t actual=running required=finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, hi0, hi1, nps, bad;
      bit first_hi, mid_hi, last_hi;

      // Reset with random inputs
      rst = 1'b1; ena = 1'(($urandom)); xu = NCH'($urandom); xd = NCH'($urandom);
      conf = 3'($urandom); mode = 1'($urandom);
      repeat (2) @(negedge clk);
      chk("reset_pwm", 32'(pwm), 32'd0);
      chk("reset_duty_o", 32'(duty_o), 32'd0);
      chk("reset_period_start", 32'(period_start), 32'd0);
      ena = 1'b1; xu = '0; xd = '0; conf = 3'd0; mode = 1'b0; rst = 1'b0;
      wait_ps(n);
      chk("first_period_len", 32'(n), 32'd15);

      // Edge mode, 5 up-steps on ch0
      repeat (5) pulse(0, 1'b1);
      @(negedge clk);
      chk("ch0_duty_5", 32'(duty_o[3:0]), 32'd5);
      chk("ch1_duty_0", 32'(duty_o[7:4]), 32'd0);
      wait_ps(n);
      window(15, hi0, hi1, nps);
      chk("ch0_high_5", 32'(hi0), 32'd5);
      chk("ch1_high_0", 32'(hi1), 32'd0);
      chk("ps_per_15", 32'(nps), 32'd1);

      // Saturation on ch1 both ways
      repeat (20) pulse(1, 1'b1);
      @(negedge clk);
      chk("ch1_sat_max", 32'(duty_o[7:4]), 32'd15);
      wait_ps(n);
      window(15, hi0, hi1, nps);
      chk("ch1_const_high", 32'(hi1), 32'd15);
      repeat (20) pulse(1, 1'b0);
      @(negedge clk);
      chk("ch1_sat_min", 32'(duty_o[7:4]), 32'd0);
      wait_ps(n);
      window(15, hi0, hi1, nps);
      chk("ch1_const_low", 32'(hi1), 32'd0);

      // Simultaneous up/down, then a mid-period up-step
      @(negedge clk); xu[0] = 1'b1; xd[0] = 1'b1;
      @(negedge clk); xu[0] = 1'b0; xd[0] = 1'b0;
      @(negedge clk);
      chk("both_edges_hold", 32'(duty_o[3:0]), 32'd5);
      wait_ps(n);
      hi0 = 0; nps = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         hi0 += int'(pwm[0]);
         nps += int'(period_start);
         if (i == 3) xu[0] = 1'b1;
         if (i == 4) begin
            chk("duty_o_next_clk", 32'(duty_o[3:0]), 32'd6);
            xu[0] = 1'b0;
         end
      end
      chk("old_width_kept", 32'(hi0), 32'd5);
      chk("old_period_ps", 32'(nps), 32'd1);
      window(15, hi0, hi1, nps);
      chk("new_width_6", 32'(hi0), 32'd6);

      // Center mode, conf=1, duty 4; mode change applies only at a boundary
      repeat (2) pulse(0, 1'b0);
      wait_ps(n);
      mode = 1'b1; conf = 3'd1;
      wait_ps(n);
      chk("edge_period_kept", 32'(n), 32'd15);
      hi0 = 0; nps = 0;
      for (int i = 0; i < 56; i++) begin
         @(negedge clk);
         hi0 += int'(pwm[0]);
         nps += int'(period_start);
         if (i == 0)  first_hi = pwm[0];
         if (i == 28) mid_hi   = pwm[0];
         if (i == 55) last_hi  = pwm[0];
      end
      chk("center_high_14", 32'(hi0), 32'd14);
      chk("center_ps_56", 32'(nps), 32'd1);
      chk("center_start_high", 32'(first_hi), 32'd1);
      chk("center_mid_low", 32'(mid_hi), 32'd0);
      chk("center_end_high", 32'(last_hi), 32'd1);
      mode = 1'b0; conf = 3'd0;
      wait_ps(n);
      chk("center_period_kept", 32'(n), 32'd56);
      wait_ps(n);
      chk("edge_again_15", 32'(n), 32'd15);

      // Freeze for 10 clocks mid-period
      repeat (5) @(negedge clk);
      ena = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (pwm !== '0 || period_start !== 1'b0) bad++;
         if (i == 2) xu[0] = 1'b1;
         if (i == 5) xu[0] = 1'b0;
      end
      ena = 1'b1;
      chk("freeze_outputs_low", 32'(bad), 32'd0);
      chk("freeze_no_edit", 32'(duty_o[3:0]), 32'd4);
      wait_ps(n);
      chk("freeze_resume_len", 32'(n), 32'd10);

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 199) == 0);
         ena = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 3) == 0) xu = NCH'($urandom);
         if ($urandom_range(0, 3) == 0) xd = NCH'($urandom);
         if ($urandom_range(0, 39) == 0) mode = 1'($urandom);
         if ($urandom_range(0, 39) == 0) conf = 3'($urandom_range(0, 2));
      end

      // Reset mid-period
      @(negedge clk); rst = 1'b1; xu = '0; xd = '0;
      @(negedge clk);
      chk("midrst_duty_o", 32'(duty_o), 32'd0);
      chk("midrst_pwm", 32'(pwm), 32'd0);
      rst = 1'b0; ena = 1'b1; mode = 1'b0; conf = 3'd0;
      wait_ps(n);
      chk("midrst_first_period", 32'(n), 32'd15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
